wb_ram512x8_ctrl: RTL and testbench

//  Wishbone-classic 32-bit slave and initiator for one 512x8 single-port SRAM macro
//  (active-low CEN, registered read data one cycle after the access edge).
//  It serialises each 32-bit word access into four byte accesses (little-endian)
//  and assembles read data.
//  It sits between the core/peripheral bus and the 8-bit RAM wrapper, giving a 128-word data RAM.

---
 rtl/wb_ram512x8_ctrl_if.sv | 26 ++
 rtl/wb_ram512x8_ctrl.sv | 117 +++++++++++
 tb/tb_wb_ram512x8_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram512x8_ctrl_if.sv
// Wishbone-classic 32-bit bus bundle for the byte-serialising RAM controller.
// AW is the word address width.
interface wb_ram512x8_ctrl_if #(
  parameter int AW = 7
);
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_ram512x8_ctrl.sv
// Wishbone 32-bit slave driving a 512x8 single-port SRAM.
// Each word access becomes four little-endian byte accesses.
module wb_ram512x8_ctrl #(
  parameter int RAM_AW     = 9,
  parameter bit SKIP_UNSEL = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_ram512x8_ctrl_if.slave wb,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [RAM_AW-1:0] ram_adr_o,
  output logic [7:0]        ram_dat_o,
  input  logic [7:0]        ram_dat_i
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    ACK
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [RAM_AW-3:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic [1:0]          pidx;

  // Read data lags the access by one cycle, so it lands one lane behind idx.
  assign pidx = idx_q - 2'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rbuf_d  = rbuf_q;
    unique case (state_q)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          state_d = XFER;
          idx_d   = 2'd0;
          adr_d   = wb.wb_adr_i;
          we_d    = wb.wb_we_i;
          sel_d   = wb.wb_sel_i;
          wdat_d  = wb.wb_dat_i;
          rbuf_d  = 32'h0;
        end
      end
      XFER: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          if (!we_q && idx_q != 2'd0)
            rbuf_d[{pidx, 3'b000} +: 8] = ram_dat_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = we_q ? ACK : DRAIN;
        end
      end
      DRAIN: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          rbuf_d[31:24] = ram_dat_i;
          state_d       = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      wdat_q  <= 32'h0;
      rbuf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rbuf_q  <= rbuf_d;
    end
  end

  logic in_xfer;
  logic sel_bit;

  assign in_xfer = (state_q == XFER);
  assign sel_bit = sel_q[idx_q];

  // Unselected write bytes either idle the RAM or become dummy reads.
  assign ram_cen_o = !(in_xfer &&
                       (!we_q || sel_bit || !SKIP_UNSEL));
  assign ram_wen_o = in_xfer && we_q && sel_bit;
  assign ram_adr_o = {adr_q, idx_q};
  assign ram_dat_o = wdat_q[{idx_q, 3'b000} +: 8];

  assign wb.wb_ack_o = (state_q == ACK);
  assign wb.wb_dat_o = (state_q == ACK && !we_q) ?
                       rbuf_q : 32'h0;

endmodule

// File: tb/tb_wb_ram512x8_ctrl.sv
// Directed bench for wb_ram512x8_ctrl with a behavioural
// 512x8 SRAM model (registered read data).
module tb_wb_ram512x8_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_cen;
  logic       ram_wen;
  logic [8:0] ram_adr;
  logic [7:0] ram_wdat;
  logic [7:0] ram_rdat;

  logic [7:0] mem [0:511];

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;

  wb_ram512x8_ctrl_if #(.AW(7)) bus ();

  wb_ram512x8_ctrl #(
    .RAM_AW(9),
    .SKIP_UNSEL(1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb        (bus),
    .ram_cen_o (ram_cen),
    .ram_wen_o (ram_wen),
    .ram_adr_o (ram_adr),
    .ram_dat_o (ram_wdat),
    .ram_dat_i (ram_rdat)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [8:0] a;
      a = i[8:0];
      mem[i] = a[7:0] ^ 8'h5A;
    end
    ram_rdat = 8'h00;
  end

  always @(posedge clk) begin
    if (!ram_cen) begin
      if (ram_wen) mem[ram_adr] <= ram_wdat;
      ram_rdat <= mem[ram_adr];
    end
  end

  always @(negedge clk) begin
    if (ram_cen === 1'b0) acc_cnt++;
    if (ram_wen === 1'b1) wr_cnt++;
    if (bus.wb_ack_o === 1'b1) ack_cnt++;
  end

  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 7'h0;
    bus.wb_sel_i = 4'h0;
    bus.wb_dat_i = 32'h0;
  endtask

  task automatic cyc_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request and wait (bounded) for ack; lat=-1 on timeout.
  task automatic do_req(input bit we, input logic [6:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output logic [31:0] rd, output int lat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    lat = -1;
    rd  = 32'hx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o === 1'b1) begin
        lat = n;
        rd  = bus.wb_dat_o;
        break;
      end
    end
    idle_bus();
    cyc_wait(1);
  endtask

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (ram_cen !== 1'b1 || ram_wen !== 1'b0 ||
          ram_adr !== 9'h0 || ram_wdat !== 8'h0 ||
          bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
        fails++;
        $display("FAIL reset%0d: cen=%b wen=%b adr=%h dat=%h ack=%b rd=%h",
                 i, ram_cen, ram_wen, ram_adr, ram_wdat,
                 bus.wb_ack_o, bus.wb_dat_o);
      end
    end
    rst = 1'b0;
    cyc_wait(1);
    chk32("idle_cen", {31'h0, ram_cen}, 32'h1);
  endtask

  task automatic test_write();
    logic [31:0] rd;
    int lat, a0, w0;
    a0 = ack_cnt;
    w0 = wr_cnt;
    do_req(1'b1, 7'h05, 4'hF, 32'hDEADBEEF, rd, lat);
    chk32("wr_lat", lat, 32'd5);
    chk32("wr_acks", ack_cnt - a0, 32'd1);
    chk32("wr_cnt", wr_cnt - w0, 32'd4);
    chk32("wr_mem", {mem[9'h17], mem[9'h16], mem[9'h15], mem[9'h14]},
          32'hDEADBEEF);
  endtask

  task automatic test_read();
    logic [31:0] rd;
    int lat, w0, a0;
    w0 = wr_cnt;
    a0 = acc_cnt;
    do_req(1'b0, 7'h05, 4'h0, 32'h0, rd, lat);
    chk32("rd_dat", rd, 32'hDEADBEEF);
    chk32("rd_lat", lat, 32'd6);
    chk32("rd_nowen", wr_cnt - w0, 32'd0);
    chk32("rd_acc", acc_cnt - a0, 32'd4);
    chk32("rd_dat_idle", bus.wb_dat_o, 32'h0);
  endtask

  task automatic test_sel();
    logic [31:0] rd;
    int lat, a0, w0;
    a0 = acc_cnt;
    w0 = wr_cnt;
    do_req(1'b1, 7'h7F, 4'b0101, 32'h11223344, rd, lat);
    chk32("sel_lat", lat, 32'd5);
    chk32("sel_wr", wr_cnt - w0, 32'd2);
    chk32("sel_acc", acc_cnt - a0, 32'd2);
    chk32("sel_mem", {mem[9'h1FF], mem[9'h1FE], mem[9'h1FD], mem[9'h1FC]},
          32'hA522A744);
    do_req(1'b0, 7'h7F, 4'hF, 32'h0, rd, lat);
    chk32("sel_rd", rd, 32'hA522A744);
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lat, a0;
    a0 = ack_cnt;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 7'h10;
    bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = 32'h55667788;
    cyc_wait(2);
    idle_bus();
    cyc_wait(8);
    chk32("abort_noack", ack_cnt - a0, 32'd0);
    chk32("abort_mem", {mem[9'h43], mem[9'h42], mem[9'h41], mem[9'h40]},
          32'h19187788);
    do_req(1'b0, 7'h10, 4'hF, 32'h0, rd, lat);
    chk32("abort_rd", rd, 32'h19187788);
    chk32("abort_rd_lat", lat, 32'd6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lat1, lat2, a0, c0, w0;
    a0 = ack_cnt;
    c0 = acc_cnt;
    w0 = wr_cnt;
    lat1 = -1;
    lat2 = -1;
    rd = 32'hx;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 7'h05;
    bus.wb_sel_i = 4'hF;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o === 1'b1) begin
        lat1 = n;
        rd = bus.wb_dat_o;
        break;
      end
    end
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 7'h20;
    bus.wb_dat_i = 32'hCAFEF00D;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o === 1'b1) begin
        lat2 = n;
        break;
      end
    end
    idle_bus();
    cyc_wait(8);
    chk32("b2b_rd", rd, 32'hDEADBEEF);
    chk32("b2b_lat1", lat1, 32'd6);
    chk32("b2b_lat2", lat2, 32'd6);
    chk32("b2b_acks", ack_cnt - a0, 32'd2);
    chk32("b2b_acc", acc_cnt - c0, 32'd8);
    chk32("b2b_wr", wr_cnt - w0, 32'd4);
    chk32("b2b_mem", {mem[9'h83], mem[9'h82], mem[9'h81], mem[9'h80]},
          32'hCAFEF00D);
  endtask

  task automatic test_reset_mid();
    int a0;
    a0 = ack_cnt;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 7'h30;
    bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = 32'h01020304;
    cyc_wait(2);
    rst = 1'b1;
    idle_bus();
    cyc_wait(1);
    tests++;
    if (ram_cen !== 1'b1 || ram_wen !== 1'b0 ||
        ram_adr !== 9'h0 || ram_wdat !== 8'h0 ||
        bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid: cen=%b wen=%b adr=%h dat=%h ack=%b rd=%h",
               ram_cen, ram_wen, ram_adr, ram_wdat,
               bus.wb_ack_o, bus.wb_dat_o);
    end
    rst = 1'b0;
    cyc_wait(8);
    chk32("rst_mid_noack", ack_cnt - a0, 32'd0);
    chk32("rst_mid_mem", {mem[9'hC3], mem[9'hC2], mem[9'hC1], mem[9'hC0]},
          32'h99980304);
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_write();
    test_read();
    test_sel();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
